// File: rtl/adder_chunked_seq.sv
// rtl/adder_chunked_seq.sv - multi-cycle chunked adder/subtractor with valid/ready handshake
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk
// first, rippling the carry through a register between cycles. A result
// with cout / signed overflow / zero flags is presented N = WIDTH/CHUNK
// cycles after the operands are accepted, and it is held until the consumer
// takes it.
//
// Parameters:
//   WIDTH      operand/result width (must be a multiple of CHUNK)
//   CHUNK      bits added per clock
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   high only while idle
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   sum        result (two's complement)
//   cout       carry out of MSB (sub: 1 = no borrow)
//   overflow   signed overflow
//   zero       sum == 0
//
// Build option:
//   ADDER_SAT_EN  when defined, an overflowing result saturates to the signed
//                 max/min selected by a[MSB]; otherwise the sum wraps.

module adder_chunked_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  // b is stored already inverted for subtraction, so CALC only ever adds.
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  // Working result assembled chunk by chunk; sum_q only changes at the end
  // so the visible result stays stable until the next one is ready.
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK:0]   chunk_add;
  logic [WIDTH-1:0] full;
  logic             ovf_w;
  logic [WIDTH-1:0] final_sum;

  assign chunk_add = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]}
                   + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};

  // Working result with the current chunk merged in; on the last chunk this
  // is the complete full-width result.
  always_comb begin
    full = res_q;
    full[cnt_q*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
  end

  assign ovf_w = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);

`ifdef ADDER_SAT_EN
  assign final_sum = !ovf_w        ? full :
                     a_q[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign final_sum = full;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = full;
        carry_d = chunk_add[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d       = final_sum;
          cout_d      = chunk_add[CHUNK];
          ovf_d       = ovf_w;
          zero_d      = ~|final_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // No accept in this cycle: a new operation starts from IDLE only.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_adder_chunked_seq.sv
// tb/tb_adder_chunked_seq.sv - directed vector bench for adder_chunked_seq

module tb_adder_chunked_seq;

  logic clk;
  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, sub8, co8, of8, z8;
  logic [7:0] a8, b8, s8;

  logic        iv32, ir32, ov32, or32, cin32, sub32, co32, of32, z32;
  logic [31:0] a32, b32, s32;

  int errors = 0;
  int checks = 0;

  adder_chunked_seq #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8),
    .overflow(of8), .zero(z8)
  );

  adder_chunked_seq u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32),
    .overflow(of32), .zero(z32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = c; sub8 = s; iv8 = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands during CALC; the result must depend only on the accepted values.
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~c; sub8 = ~s;
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (!ov8 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run32(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] es, input logic ec, input logic eo, input logic ez);
    int cyc;
    logic [31:0] xs;
    logic xz;
    xs = es; xz = ez;
`ifdef ADDER_SAT_EN
    if (eo) begin
      xs = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      xz = 1'b0;
    end
`endif
    @(negedge clk);
    a32 = av; b32 = bv; cin32 = 1'b0; sub32 = 1'b0; iv32 = 1'b1;
    @(posedge clk);
    #1;
    iv32 = 1'b0; a32 = '0; b32 = '0;
    cyc = 0;
    while (!ov32 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("w32 latency", cyc, 4);
    chk("w32 sum", s32, xs);
    chk("w32 cout", co32, ec);
    chk("w32 overflow", of32, eo);
    chk("w32 zero", z32, xz);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [7:0] es;
    logic ez;

    tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h05, 8'h0A, 1'b0, 1'b1, 8'hFB, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'hFE, 8'hFD, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h05, 8'h0A, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;

    #12;
    chk("reset in_ready", ir8, 1'b1);
    chk("reset out_valid", ov8, 1'b0);
    chk("reset sum", s8, 8'h00);
    chk("reset cout", co8, 1'b0);
    chk("reset overflow", of8, 1'b0);
    chk("reset zero", z8, 1'b0);
    chk("reset w32 in_ready", ir32, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      es = tbl[i].s;
      ez = tbl[i].z;
`ifdef ADDER_SAT_EN
      if (tbl[i].o) begin
        es = tbl[i].a[7] ? 8'h80 : 8'h7F;
        ez = 1'b0;
      end
`endif
      start8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      chk($sformatf("v%0d busy in_ready", i), ir8, 1'b0);
      wait8(cyc);
      chk($sformatf("v%0d latency", i), cyc, 2);
      chk($sformatf("v%0d sum", i), s8, es);
      chk($sformatf("v%0d cout", i), co8, tbl[i].c);
      chk($sformatf("v%0d overflow", i), of8, tbl[i].o);
      chk($sformatf("v%0d zero", i), z8, ez);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid drop", i), ov8, 1'b0);
      chk($sformatf("v%0d sum held", i), s8, es);
    end

    // Backpressure: result held, new requests ignored.
    or8 = 1'b0;
    start8(8'h05, 8'h0A, 1'b0, 1'b0);
    wait8(cyc);
    chk("bp latency", cyc, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv8 = (k % 2 == 0); a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b1; sub8 = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d out_valid", k), ov8, 1'b1);
      chk($sformatf("bp%0d sum", k), s8, 8'h0F);
      chk($sformatf("bp%0d flags", k), {co8, of8, z8}, 3'b000);
      chk($sformatf("bp%0d in_ready", k), ir8, 1'b0);
    end
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release out_valid", ov8, 1'b0);
    chk("bp release in_ready", ir8, 1'b1);
    chk("bp release sum", s8, 8'h0F);
    @(posedge clk);
    #1;
    chk("bp no queued op in_ready", ir8, 1'b1);
    chk("bp no queued op out_valid", ov8, 1'b0);

    // Reset while a result is waiting in DONE.
    or8 = 1'b0;
    start8(8'h3C, 8'h45, 1'b1, 1'b0);
    wait8(cyc);
    chk("rstdone pre out_valid", ov8, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstdone out_valid", ov8, 1'b0);
    chk("rstdone in_ready", ir8, 1'b1);
    chk("rstdone sum", s8, 8'h00);
    chk("rstdone overflow", of8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    or8 = 1'b1;

    // Reset mid-CALC, then a fresh operation.
    start8(8'h7F, 8'h01, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstcalc out_valid", ov8, 1'b0);
    chk("rstcalc in_ready", ir8, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    start8(8'h05, 8'h0A, 1'b0, 1'b0);
    wait8(cyc);
    chk("post-reset latency", cyc, 2);
    chk("post-reset sum", s8, 8'h0F);
    chk("post-reset overflow", of8, 1'b0);
    @(posedge clk);
    #1;

    // Default parameters: WIDTH=32, CHUNK=8.
    run32(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run32(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run32(32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
